// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares the DDR burst-read port between ISA refills and the
// data-side operand loader. One whole burst is granted at a time; beats and a
// saturating beat counter go back to the owner only, and the grant is held
// until the owner drops its request.
// Build option: define ARB_FIXED_PRIO_EN to make ISA win every tie
// (default is round-robin against the last owner).
module ddr_rd_arbiter #(
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int DDR_DATA_WIDTH = 32,
   parameter int ISA_WIDTH      = 30,
   parameter int LEN_WIDTH      = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      isa_rd_req,
   input  logic [DDR_ADDR_WIDTH-1:0] isa_rd_addr,
   input  logic [LEN_WIDTH-1:0]      isa_rd_len,
   output logic [ISA_WIDTH-1:0]      isa_rd_data,
   output logic                      isa_rd_valid,
   output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
   input  logic                      dat_rd_req,
   input  logic [DDR_ADDR_WIDTH-1:0] dat_rd_addr,
   input  logic [LEN_WIDTH-1:0]      dat_rd_len,
   output logic [DDR_DATA_WIDTH-1:0] dat_rd_data,
   output logic                      dat_rd_valid,
   output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
   output logic                      rd_burst_req,
   output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
   output logic [LEN_WIDTH-1:0]      rd_burst_len,
   input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
   input  logic                      rd_burst_data_valid,
   input  logic                      rd_burst_finish,
   output logic [1:0]                owner,
   output logic                      len_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST, S_DONE} state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_ISA  = 2'd1;
   localparam logic [1:0] OWN_DAT  = 2'd2;

   state_t                    state, state_nxt;
   logic                      grant_isa, grant_dat;
   logic                      beat_take, fin_take, rel_owner;
   logic                      tie_isa;
   logic                      own_req;
   logic [LEN_WIDTH-1:0]      own_cnt;
   logic [DDR_ADDR_WIDTH-1:0] sel_addr;
   logic [LEN_WIDTH-1:0]      sel_len;

   // A beat is only accepted while the owner's counter is below the burst length.
   function automatic logic beat_room(input logic [LEN_WIDTH-1:0] cnt,
                                      input logic [LEN_WIDTH-1:0] len);
      return cnt < len;
   endfunction

   // Count including a beat accepted in the finish cycle, compared against length.
   function automatic logic short_burst(input logic [LEN_WIDTH-1:0] cnt,
                                        input logic                 take,
                                        input logic [LEN_WIDTH-1:0] len);
      logic [LEN_WIDTH:0] total;
      total = {1'b0, cnt} + {{LEN_WIDTH{1'b0}}, take};
      return total < {1'b0, len};
   endfunction

   assign own_req  = (owner == OWN_ISA) ? isa_rd_req : dat_rd_req;
   assign own_cnt  = (owner == OWN_ISA) ? isa_rd_cnt : dat_rd_cnt;
   assign sel_addr = grant_isa ? isa_rd_addr : dat_rd_addr;
   assign sel_len  = grant_isa ? isa_rd_len  : dat_rd_len;

`ifdef ARB_FIXED_PRIO_EN
   assign tie_isa = 1'b1;
`else
   logic last_dat;

   assign tie_isa = last_dat;

   // Remember who was granted last so a tie goes to the other requester.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           last_dat <= 1'b1;
      else if (grant_isa) last_dat <= 1'b0;
      else if (grant_dat) last_dat <= 1'b1;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic: arbitration in IDLE, beat/finish qualification in BURST.
   always_comb begin
      state_nxt = state;
      grant_isa = 1'b0;
      grant_dat = 1'b0;
      beat_take = 1'b0;
      fin_take  = 1'b0;
      rel_owner = 1'b0;
      case (state)
         S_IDLE: begin
            if (isa_rd_req && dat_rd_req) begin
               grant_isa = tie_isa;
               grant_dat = !tie_isa;
            end else begin
               grant_isa = isa_rd_req;
               grant_dat = dat_rd_req;
            end
            if (grant_isa)      state_nxt = (isa_rd_len == '0) ? S_DONE : S_ISSUE;
            else if (grant_dat) state_nxt = (dat_rd_len == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: state_nxt = S_BURST;
         S_BURST: begin
            beat_take = rd_burst_data_valid && beat_room(own_cnt, rd_burst_len);
            if (rd_burst_finish) begin
               fin_take  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!own_req) begin
               rel_owner = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant latching, beat routing to the owner, counters and the error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner         <= OWN_NONE;
         rd_burst_req  <= 1'b0;
         rd_burst_addr <= '0;
         rd_burst_len  <= '0;
         isa_rd_data   <= '0;
         isa_rd_valid  <= 1'b0;
         isa_rd_cnt    <= '0;
         dat_rd_data   <= '0;
         dat_rd_valid  <= 1'b0;
         dat_rd_cnt    <= '0;
         len_err       <= 1'b0;
      end else begin
         isa_rd_valid <= 1'b0;
         dat_rd_valid <= 1'b0;
         if (grant_isa || grant_dat) begin
            rd_burst_addr <= sel_addr;
            rd_burst_len  <= sel_len;
            rd_burst_req  <= (sel_len != '0);
            owner         <= grant_isa ? OWN_ISA : OWN_DAT;
            if (grant_isa) isa_rd_cnt <= '0;
            else           dat_rd_cnt <= '0;
         end
         if (beat_take) begin
            if (owner == OWN_ISA) begin
               isa_rd_data  <= rd_burst_data[ISA_WIDTH-1:0];
               isa_rd_valid <= 1'b1;
               isa_rd_cnt   <= isa_rd_cnt + 1'b1;
            end else begin
               dat_rd_data  <= rd_burst_data;
               dat_rd_valid <= 1'b1;
               dat_rd_cnt   <= dat_rd_cnt + 1'b1;
            end
         end
         if (fin_take) begin
            rd_burst_req <= 1'b0;
            if (short_burst(own_cnt, beat_take, rd_burst_len)) len_err <= 1'b1;
         end
         if (rel_owner) owner <= OWN_NONE;
      end
   end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Scoreboard bench for ddr_rd_arbiter: the stimulus pushes expected beats and
// expected signal probes into queues; a negedge monitor pops and compares.
module tb_ddr_rd_arbiter;

   localparam int AW = 28;
   localparam int DW = 32;
   localparam int IW = 30;
   localparam int LW = 10;

   localparam int SIG_OWNER   = 0;
   localparam int SIG_BREQ    = 1;
   localparam int SIG_BADDR   = 2;
   localparam int SIG_BLEN    = 3;
   localparam int SIG_ISACNT  = 4;
   localparam int SIG_DATCNT  = 5;
   localparam int SIG_LENERR  = 6;
   localparam int SIG_ISAV    = 7;
   localparam int SIG_DATV    = 8;
   localparam int SIG_DATDATA = 9;
   localparam int SIG_ISADATA = 10;
   localparam int SIG_QLEN    = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          isa_rd_req = 1'b0;
   logic [AW-1:0] isa_rd_addr = '0;
   logic [LW-1:0] isa_rd_len = '0;
   logic [IW-1:0] isa_rd_data;
   logic          isa_rd_valid;
   logic [LW-1:0] isa_rd_cnt;
   logic          dat_rd_req = 1'b0;
   logic [AW-1:0] dat_rd_addr = '0;
   logic [LW-1:0] dat_rd_len = '0;
   logic [DW-1:0] dat_rd_data;
   logic          dat_rd_valid;
   logic [LW-1:0] dat_rd_cnt;
   logic          rd_burst_req;
   logic [AW-1:0] rd_burst_addr;
   logic [LW-1:0] rd_burst_len;
   logic [DW-1:0] rd_burst_data = '0;
   logic          rd_burst_data_valid = 1'b0;
   logic          rd_burst_finish = 1'b0;
   logic [1:0]    owner;
   logic          len_err;

   typedef struct {
      int          who;
      logic [9:0]  cnt;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      int          sig;
      logic [63:0] val;
   } probe_t;

   beat_t  exp_q[$];
   probe_t probe_q[$];
   int     checks = 0;
   int     failures = 0;

   always #5 clk = ~clk;

   ddr_rd_arbiter #(
      .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .ISA_WIDTH(IW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .isa_rd_req(isa_rd_req), .isa_rd_addr(isa_rd_addr), .isa_rd_len(isa_rd_len),
      .isa_rd_data(isa_rd_data), .isa_rd_valid(isa_rd_valid), .isa_rd_cnt(isa_rd_cnt),
      .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_len(dat_rd_len),
      .dat_rd_data(dat_rd_data), .dat_rd_valid(dat_rd_valid), .dat_rd_cnt(dat_rd_cnt),
      .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
      .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
      .rd_burst_finish(rd_burst_finish), .owner(owner), .len_err(len_err)
   );

   function automatic string sig_name(input int s);
      case (s)
         SIG_OWNER:   return "owner";
         SIG_BREQ:    return "rd_burst_req";
         SIG_BADDR:   return "rd_burst_addr";
         SIG_BLEN:    return "rd_burst_len";
         SIG_ISACNT:  return "isa_rd_cnt";
         SIG_DATCNT:  return "dat_rd_cnt";
         SIG_LENERR:  return "len_err";
         SIG_ISAV:    return "isa_rd_valid";
         SIG_DATV:    return "dat_rd_valid";
         SIG_DATDATA: return "dat_rd_data";
         SIG_ISADATA: return "isa_rd_data";
         SIG_QLEN:    return "pending_beats";
         default:     return "unknown";
      endcase
   endfunction

   function automatic logic [63:0] sample(input int s);
      case (s)
         SIG_OWNER:   return 64'(owner);
         SIG_BREQ:    return 64'(rd_burst_req);
         SIG_BADDR:   return 64'(rd_burst_addr);
         SIG_BLEN:    return 64'(rd_burst_len);
         SIG_ISACNT:  return 64'(isa_rd_cnt);
         SIG_DATCNT:  return 64'(dat_rd_cnt);
         SIG_LENERR:  return 64'(len_err);
         SIG_ISAV:    return 64'(isa_rd_valid);
         SIG_DATV:    return 64'(dat_rd_valid);
         SIG_DATDATA: return 64'(dat_rd_data);
         SIG_ISADATA: return 64'(isa_rd_data);
         SIG_QLEN:    return 64'(exp_q.size());
         default:     return '1;
      endcase
   endfunction

   // Compare one delivered beat against the head of the expected-beat queue.
   task automatic chk_beat(input int who, input logic [9:0] cnt, input logic [31:0] data);
      beat_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL beat_unexpected: got who=%0d cnt=%0d data=%h, required no strobe",
                  who, cnt, data);
      end else begin
         e = exp_q.pop_front();
         if (e.who != who || e.cnt !== cnt || e.data !== data) begin
            failures++;
            $display("FAIL beat: got who=%0d cnt=%0d data=%h, required who=%0d cnt=%0d data=%h",
                     who, cnt, data, e.who, e.cnt, e.data);
         end
      end
   endtask

   // Monitor: strobes are scored against the beat queue, then pending probes are evaluated.
   always @(negedge clk) begin
      probe_t      p;
      logic [63:0] v;
      if (isa_rd_valid) chk_beat(1, isa_rd_cnt, {2'b00, isa_rd_data});
      if (dat_rd_valid) chk_beat(2, dat_rd_cnt, dat_rd_data);
      while (probe_q.size() > 0) begin
         p = probe_q.pop_front();
         v = sample(p.sig);
         checks++;
         if (v !== p.val) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", sig_name(p.sig), v, p.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int s, input logic [63:0] v);
      probe_t p;
      p.sig = s;
      p.val = v;
      probe_q.push_back(p);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      isa_rd_req = 1'b0;
      dat_rd_req = 1'b0;
      rd_burst_data_valid = 1'b0;
      rd_burst_finish = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Drive n DDR beats first, first+1, ...; only the first len are expected at the owner.
   task automatic ddr_beats(input int who, input int n, input int len, input logic [31:0] first);
      beat_t e;
      for (int i = 0; i < n; i++) begin
         rd_burst_data = first + 32'(i);
         rd_burst_data_valid = 1'b1;
         if (i < len) begin
            e.who  = who;
            e.cnt  = 10'(i + 1);
            e.data = (who == 1) ? (rd_burst_data & 32'h3fff_ffff) : rd_burst_data;
            exp_q.push_back(e);
         end
         tick();
      end
      rd_burst_data_valid = 1'b0;
   endtask

   task automatic ddr_finish();
      rd_burst_finish = 1'b1;
      tick();
      rd_burst_finish = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      tick();
      probe(SIG_OWNER, 0); probe(SIG_BREQ, 0); probe(SIG_BADDR, 0); probe(SIG_BLEN, 0);
      probe(SIG_ISACNT, 0); probe(SIG_DATCNT, 0); probe(SIG_LENERR, 0);
      probe(SIG_ISAV, 0); probe(SIG_DATV, 0);
      tick();
      rst = 1'b1;
      tick();

      // ISA only, len 4, beats 0x11..0x14
      isa_rd_req = 1'b1; isa_rd_addr = 28'h100; isa_rd_len = 10'd4;
      probe(SIG_BREQ, 0);
      tick();
      probe(SIG_BREQ, 1); probe(SIG_OWNER, 1); probe(SIG_BADDR, 28'h100); probe(SIG_BLEN, 4);
      tick();
      ddr_beats(1, 4, 4, 32'h11);
      probe(SIG_ISACNT, 4); probe(SIG_ISADATA, 32'h14);
      ddr_finish();
      probe(SIG_BREQ, 0); probe(SIG_OWNER, 1); probe(SIG_LENERR, 0);
      tick();
      probe(SIG_OWNER, 1);
      isa_rd_req = 1'b0;
      tick();
      probe(SIG_OWNER, 0);
      tick();

      // Simultaneous requests after reset: ISA, then data, then ISA again
      do_reset();
      isa_rd_req = 1'b1; isa_rd_addr = 28'h200; isa_rd_len = 10'd2;
      dat_rd_req = 1'b1; dat_rd_addr = 28'h300; dat_rd_len = 10'd2;
      tick();
      probe(SIG_OWNER, 1); probe(SIG_BADDR, 28'h200);
      tick();
      ddr_beats(1, 2, 2, 32'h21);
      ddr_finish();
      isa_rd_req = 1'b0;
      tick();
      probe(SIG_OWNER, 0); probe(SIG_BREQ, 0);
      tick();
      probe(SIG_OWNER, 2); probe(SIG_BADDR, 28'h300); probe(SIG_BREQ, 1);
      tick();
      ddr_beats(2, 2, 2, 32'hA1);
      ddr_finish();
      probe(SIG_DATCNT, 2);
      dat_rd_req = 1'b0;
      tick();
      isa_rd_req = 1'b1; dat_rd_req = 1'b1;
      tick();
      probe(SIG_OWNER, 1); probe(SIG_BADDR, 28'h200);
      dat_rd_req = 1'b0;
      tick();
      ddr_beats(1, 2, 2, 32'h25);
      ddr_finish();
      isa_rd_req = 1'b0;
      tick();
      probe(SIG_OWNER, 0);
      tick();

      // Data request arriving mid-ISA-burst waits for ISA to finish
      isa_rd_req = 1'b1; isa_rd_addr = 28'h400; isa_rd_len = 10'd2;
      tick();
      tick();
      ddr_beats(1, 1, 1, 32'h41);
      dat_rd_req = 1'b1; dat_rd_addr = 28'h500; dat_rd_len = 10'd1;
      rd_burst_data = 32'h42; rd_burst_data_valid = 1'b1;
      exp_q.push_back('{who: 1, cnt: 10'd2, data: 32'h42});
      tick();
      rd_burst_data_valid = 1'b0;
      ddr_finish();
      probe(SIG_BREQ, 0); probe(SIG_OWNER, 1);
      tick();
      probe(SIG_BREQ, 0); probe(SIG_OWNER, 1); probe(SIG_BADDR, 28'h400);
      isa_rd_req = 1'b0;
      tick();
      probe(SIG_BREQ, 0); probe(SIG_OWNER, 0);
      tick();
      probe(SIG_OWNER, 2); probe(SIG_BADDR, 28'h500); probe(SIG_BLEN, 1); probe(SIG_BREQ, 1);
      dat_rd_addr = 28'h7ff; dat_rd_len = 10'd9;
      tick();
      probe(SIG_BADDR, 28'h500); probe(SIG_BLEN, 1);
      ddr_beats(2, 1, 1, 32'hB1);
      ddr_finish();
      dat_rd_req = 1'b0;
      tick();
      tick();

      // len 3 with 5 DDR beats: counter saturates, 3 strobes only
      isa_rd_req = 1'b1; isa_rd_addr = 28'h600; isa_rd_len = 10'd3;
      tick();
      tick();
      ddr_beats(1, 5, 3, 32'h31);
      ddr_finish();
      probe(SIG_ISACNT, 3); probe(SIG_LENERR, 0); probe(SIG_ISADATA, 32'h33);
      isa_rd_req = 1'b0;
      tick();
      tick();

      // len 4, finish after 2 beats: sticky len_err
      dat_rd_req = 1'b1; dat_rd_addr = 28'h340; dat_rd_len = 10'd4;
      tick();
      tick();
      ddr_beats(2, 2, 4, 32'h51);
      ddr_finish();
      probe(SIG_LENERR, 1); probe(SIG_DATCNT, 2); probe(SIG_BREQ, 0);
      dat_rd_req = 1'b0;
      tick();
      tick();
      probe(SIG_LENERR, 1); probe(SIG_OWNER, 0);

      // len 0: no DDR request, counter cleared
      isa_rd_req = 1'b1; isa_rd_addr = 28'h660; isa_rd_len = 10'd0;
      tick();
      probe(SIG_OWNER, 1); probe(SIG_BREQ, 0); probe(SIG_ISACNT, 0); probe(SIG_BLEN, 0);
      tick();
      probe(SIG_BREQ, 0); probe(SIG_OWNER, 1);
      isa_rd_req = 1'b0;
      tick();
      probe(SIG_OWNER, 0);
      tick();

      // Reset mid-burst; stray beats afterwards are ignored
      dat_rd_req = 1'b1; dat_rd_addr = 28'h700; dat_rd_len = 10'd4;
      tick();
      tick();
      ddr_beats(2, 1, 4, 32'hC1);
      tick();
      rst = 1'b0;
      dat_rd_req = 1'b0;
      tick();
      probe(SIG_OWNER, 0); probe(SIG_BREQ, 0); probe(SIG_DATCNT, 0); probe(SIG_DATDATA, 0);
      probe(SIG_LENERR, 0); probe(SIG_BADDR, 0); probe(SIG_BLEN, 0);
      rst = 1'b1;
      tick();
      ddr_beats(2, 3, 0, 32'hD1);
      ddr_finish();
      probe(SIG_DATCNT, 0); probe(SIG_OWNER, 0); probe(SIG_BREQ, 0);
      tick();
      probe(SIG_QLEN, 0);
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
